peak_meter: RTL and testbench
=============================

PEAK_METER -- requirements
Module: peak_meter

Interface
REQ-001 Parameter SAMPLE_W, default 12: mic sample width, offset-binary; midpoint is 2^(SAMPLE_W-1).
REQ-002 Parameter LEVEL_W, default 4: level width; levels run 0..2^LEVEL_W-1.
REQ-003 Parameter DIV, default 5000: clk cycles per sample tick (20 kHz at 100 MHz); legal range is 2 or more.
REQ-004 Parameter WINDOW, default 5000: sample ticks per measurement window; legal range is 2 or more.
REQ-005 Parameter HOLD_WIN, default 4: windows the peak is held before decay starts; legal range is 1 or more.
REQ-006 clk  input  1  system clock; all logic is single-domain on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 mic_in  input  SAMPLE_W  raw microphone sample.
REQ-009 hold_en  input  1  1 = peak-hold mode, 0 = instantaneous mode.
REQ-010 level  output  LEVEL_W  registered level of the most recently completed window.
REQ-011 peak  output  LEVEL_W  registered peak-hold level.
REQ-012 level_valid  output  1  one-clk pulse when level and peak update.
REQ-013 led  output  2^LEVEL_W-1  thermometer bar of the displayed level.

Function
REQ-014 Tick counter runs 0..DIV-1; tick is asserted for one clk when the counter equals DIV-1, then the counter wraps to 0.
REQ-015 Samples are taken only on tick; mic_in is ignored on all other cycles.
REQ-016 Sample counter runs 0..WINDOW-1 and advances on tick only, so each window holds exactly WINDOW samples.
REQ-017 Running max: on the tick where the sample counter is 0, max is loaded with mic_in; on every other tick, max becomes max(max, mic_in), unsigned.
REQ-018 Window end is the tick where the sample counter equals WINDOW-1; m = max(max, mic_in) on that tick, so the final sample is included.
REQ-019 Level mapping: if m[SAMPLE_W-1] = 1, level = m[SAMPLE_W-2 : SAMPLE_W-1-LEVEL_W]; otherwise level = 0; the result is truncated, with no rounding.
REQ-020 level, peak and level_valid update on the same clk edge that processes the window-end tick; latency is 0 clk after the tick edge.
REQ-021 level_valid is 1 only in the clk cycle after that edge and 0 otherwise.
REQ-022 Peak FSM states: HOLD and DECAY; a 2-bit hold_cnt counts windows spent in HOLD; the FSM is evaluated at window end only.
REQ-023 hold_en = 0 at window end: peak = level, state = HOLD, hold_cnt = 0.
REQ-024 hold_en = 1 and level >= peak, in any state: peak = level, state = HOLD, hold_cnt = 0.
REQ-025 hold_en = 1, state HOLD, level < peak:
- if hold_cnt = HOLD_WIN-1, go to DECAY;
- otherwise increment hold_cnt.
REQ-026 hold_en = 1, state DECAY, level < peak: peak = max(peak-1, level); peak never goes below level and never underflows.
REQ-027 DECAY ends only through REQ-024, i.e. when level >= peak.
REQ-028 Display value disp = peak when hold_en = 1, level otherwise; led[i] = 1 iff i < disp; led is combinational from registers.
REQ-029 Toggling hold_en mid-window does not disturb the max accumulation; the new mode takes effect on led immediately and on peak at the next window end.

Reset
REQ-030 When rst = 1 at a clk edge, the following are cleared:
- tick counter, sample counter and max to 0;
- level, peak, level_valid and hold_cnt to 0;
- state to HOLD.
REQ-031 rst mid-window discards the partial window; the first level_valid after rst release comes after exactly DIV*WINDOW clks.
REQ-032 rst has priority over a coincident tick or window end.

Structure
REQ-033 Package peak_meter_pkg holds the FSM state enum (HOLD, DECAY) and a function mapping a SAMPLE_W max to a LEVEL_W level.
REQ-034 Sub-module tick_gen (parameter DIV; ports clk, rst, tick) generates the one-clk sample strobe; no derived clocks are used.

Verification (all scenarios use DIV=2, WINDOW=4, HOLD_WIN=2)
REQ-035 Reset: rst held 3 clks, then released -> level, peak, level_valid and led are 0; first level_valid occurs 8 clks after release.
REQ-036 mic_in constant 12'hC80 -> level = 9, led = 15'h01FF, one level_valid pulse every 8 clks.
REQ-037 mic_in constant 12'h7FF -> level = 0, led = 0.
REQ-038 Window samples 12'h800, 12'hFFF, 12'h900, 12'h800 -> level = 15, led = 15'h7FFF; a max on the final sample only (12'h800, 12'h800, 12'h800, 12'hFFF) -> level = 15.
REQ-039 hold_en = 1, one window at level 12, then windows at level 3 -> peak sequence 12, 12, 12, 11, 10, ..., 4, 3, 3; led follows peak; a level-14 window mid-decay -> peak = 14 and hold restarts.
REQ-040 rst asserted after 2 ticks of a window with mic_in = 12'hFFF, then mic_in = 12'h880 -> next level = 1, with no trace of 12'hFFF.

Source files
------------

// File: rtl/peak_meter_pkg.sv
// rtl/peak_meter_pkg.sv - shared types and helpers for the microphone peak meter
package peak_meter_pkg;

    typedef enum logic {
        HOLD  = 1'b0,
        DECAY = 1'b1
    } peak_state_e;

    // Levels below the offset-binary midpoint read as silence; above it the
    // top LEVEL_W magnitude bits are taken as-is, with no rounding.
    function automatic logic [31:0] map_level(input logic [31:0] m,
                                              input int sample_w,
                                              input int level_w);
        logic [31:0] mask;
        mask = (32'd1 << level_w) - 32'd1;
        if (m[sample_w-1]) begin
            return (m >> (sample_w - 1 - level_w)) & mask;
        end
        return 32'd0;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - one-clk sample strobe every DIV clocks
module tick_gen #(
    parameter int DIV = 5000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/peak_meter.sv
// rtl/peak_meter.sv - windowed peak level meter with peak-hold and LED bar
module peak_meter
    import peak_meter_pkg::*;
#(
    parameter int SAMPLE_W = 12,
    parameter int LEVEL_W  = 4,
    parameter int DIV      = 5000,
    parameter int WINDOW   = 5000,
    parameter int HOLD_WIN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SAMPLE_W-1:0]        mic_in,
    input  logic                       hold_en,
    output logic [LEVEL_W-1:0]         level,
    output logic [LEVEL_W-1:0]         peak,
    output logic                       level_valid,
    output logic [(2**LEVEL_W)-2:0]    led
);

    localparam int SCW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int LED_W = (2**LEVEL_W) - 1;
    localparam logic [SCW-1:0] S_LAST = SCW'(WINDOW - 1);
    localparam logic [1:0]     H_LAST = 2'(HOLD_WIN - 1);

    logic                 tick;
    logic [SCW-1:0]       samp_cnt;
    logic [SAMPLE_W-1:0]  max_r;
    logic [SAMPLE_W-1:0]  m_win;
    logic                 window_end;
    logic [LEVEL_W-1:0]   lvl_new;
    logic [LEVEL_W-1:0]   peak_dec;
    logic [LEVEL_W-1:0]   disp;

    peak_state_e          state, state_nx;
    logic [1:0]           hold_cnt, hold_nx;
    logic [LEVEL_W-1:0]   peak_nx;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign m_win      = (mic_in > max_r) ? mic_in : max_r;
    assign window_end = tick && (samp_cnt == S_LAST);
    assign lvl_new    = LEVEL_W'(map_level(32'(m_win), SAMPLE_W, LEVEL_W));
    assign peak_dec   = peak - LEVEL_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt    <= '0;
            max_r       <= '0;
            level       <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= window_end;
            if (tick) begin
                samp_cnt <= (samp_cnt == S_LAST) ? '0 : samp_cnt + SCW'(1);
                max_r    <= (samp_cnt == '0) ? mic_in : m_win;
            end
            if (window_end) begin
                level <= lvl_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HOLD;
            hold_cnt <= 2'd0;
            peak     <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
            peak     <= peak_nx;
        end
    end

    // The peak FSM only moves at window end, against the level being latched
    // on that same edge.
    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        peak_nx  = peak;
        if (window_end) begin
            if (!hold_en || (lvl_new >= peak)) begin
                peak_nx  = lvl_new;
                state_nx = HOLD;
                hold_nx  = 2'd0;
            end else if (state == HOLD) begin
                if (hold_cnt == H_LAST) begin
                    state_nx = DECAY;
                end else begin
                    hold_nx = hold_cnt + 2'd1;
                end
            end else begin
                peak_nx = (peak_dec > lvl_new) ? peak_dec : lvl_new;
            end
        end
    end

    assign disp = hold_en ? peak : level;

    always_comb begin
        led = '0;
        for (int i = 0; i < LED_W; i++) begin
            led[i] = (i < int'(disp));
        end
    end

endmodule

// File: tb/tb_peak_meter.sv
// tb/tb_peak_meter.sv - table-driven self-checking bench for peak_meter
module tb_peak_meter;

    logic        clk;
    logic        rst;
    logic [11:0] mic_in;
    logic        hold_en;
    logic [3:0]  level;
    logic [3:0]  peak;
    logic        level_valid;
    logic [14:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [11:0] s0, s1, s2, s3;
        logic        hold;
        logic [3:0]  lvl;
        logic [3:0]  pk;
        logic [14:0] led;
    } vec_t;

    vec_t vecs[$];

    peak_meter #(
        .SAMPLE_W (12),
        .LEVEL_W  (4),
        .DIV      (2),
        .WINDOW   (4),
        .HOLD_WIN (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mic_in      (mic_in),
        .hold_en     (hold_en),
        .level       (level),
        .peak        (peak),
        .level_valid (level_valid),
        .led         (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [11:0] s0, s1, s2, s3, input logic h,
                       input int lvl, input int pk);
        vec_t v;
        int   disp;
        v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3;
        v.hold = h;
        v.lvl = 4'(lvl);
        v.pk  = 4'(pk);
        disp = h ? pk : lvl;
        v.led = 15'((32'd1 << disp) - 32'd1);
        vecs.push_back(v);
    endtask

    // Each sample is held for DIV=2 clocks so exactly one tick edge sees it.
    task automatic drive_sample(input logic [11:0] s, inout int pulses);
        mic_in = s;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            pulses += int'(level_valid);
        end
    endtask

    task automatic run_window(input vec_t v, input int idx);
        int pulses;
        pulses = 0;
        hold_en = v.hold;
        drive_sample(v.s0, pulses);
        drive_sample(v.s1, pulses);
        drive_sample(v.s2, pulses);
        drive_sample(v.s3, pulses);
        check($sformatf("v%0d level_valid", idx), 32'(level_valid), 32'd1);
        check($sformatf("v%0d pulse_count", idx), 32'(pulses), 32'd1);
        check($sformatf("v%0d level", idx), 32'(level), 32'(v.lvl));
        check($sformatf("v%0d peak", idx), 32'(peak), 32'(v.pk));
        check($sformatf("v%0d led", idx), 32'(led), 32'(v.led));
    endtask

    initial begin
        int   pulses;
        vec_t v;

        // Instantaneous mode
        add(12'hC80, 12'hC80, 12'hC80, 12'hC80, 1'b0, 9, 9);
        add(12'hC80, 12'hC80, 12'hC80, 12'hC80, 1'b0, 9, 9);
        add(12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 1'b0, 0, 0);
        add(12'h800, 12'hFFF, 12'h900, 12'h800, 1'b0, 15, 15);
        add(12'h800, 12'h800, 12'h800, 12'hFFF, 1'b0, 15, 15);
        add(12'h880, 12'h880, 12'h880, 12'h880, 1'b0, 1, 1);
        // Peak hold: 12 held for two windows, then decay to level 3
        add(12'hE00, 12'hE00, 12'hE00, 12'hE00, 1'b1, 12, 12);
        add(12'h980, 12'h980, 12'h980, 12'h980, 1'b1, 3, 12);
        add(12'h980, 12'h980, 12'h980, 12'h980, 1'b1, 3, 12);
        for (int p = 11; p >= 3; p--) add(12'h980, 12'h980, 12'h980, 12'h980, 1'b1, 3, p);
        add(12'h980, 12'h980, 12'h980, 12'h980, 1'b1, 3, 3);
        // Louder window mid-decay restarts the hold
        add(12'hE00, 12'hE00, 12'hE00, 12'hE00, 1'b1, 12, 12);
        add(12'h980, 12'h980, 12'h980, 12'h980, 1'b1, 3, 12);
        add(12'h980, 12'h980, 12'h980, 12'h980, 1'b1, 3, 12);
        add(12'h980, 12'h980, 12'h980, 12'h980, 1'b1, 3, 11);
        add(12'hF00, 12'hF00, 12'hF00, 12'hF00, 1'b1, 14, 14);
        add(12'h980, 12'h980, 12'h980, 12'h980, 1'b1, 3, 14);
        add(12'h980, 12'h980, 12'h980, 12'h980, 1'b1, 3, 14);
        add(12'h980, 12'h980, 12'h980, 12'h980, 1'b1, 3, 13);

        rst = 1'b1;
        mic_in = 12'h000;
        hold_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset level", 32'(level), 32'd0);
        check("reset peak", 32'(peak), 32'd0);
        check("reset level_valid", 32'(level_valid), 32'd0);
        check("reset led", 32'(led), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_window(vecs[i], i);

        // Mode switch reaches led at once; peak stays 13, level stays 3
        hold_en = 1'b0;
        #1;
        check("toggle led level", 32'(led), 32'h0007);
        hold_en = 1'b1;
        #1;
        check("toggle led peak", 32'(led), 32'h1FFF);
        check("toggle peak kept", 32'(peak), 32'd13);

        v = '{s0: 12'h980, s1: 12'h980, s2: 12'h980, s3: 12'h980,
              hold: 1'b0, lvl: 4'd3, pk: 4'd3, led: 15'h0007};
        run_window(v, 100);

        // Reset two ticks into a loud window, spanning a tick edge
        pulses = 0;
        drive_sample(12'hFFF, pulses);
        drive_sample(12'hFFF, pulses);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midreset level", 32'(level), 32'd0);
        check("midreset peak", 32'(peak), 32'd0);
        check("midreset led", 32'(led), 32'd0);
        rst = 1'b0;
        v = '{s0: 12'h880, s1: 12'h880, s2: 12'h880, s3: 12'h880,
              hold: 1'b0, lvl: 4'd1, pk: 4'd1, led: 15'h0001};
        run_window(v, 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
